// File: rtl/i2c_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_arbiter_if
// Purpose  : Bundles the requester-side and i2c_master-side command/data
//            channels of i2c_cmd_arbiter.
// Modports : slave  - arbiter view (serves the requesters, drives m_*)
//            master - environment view (requesters plus the i2c_master)
// Ports    : req_*  per-requester command/data channels, bit/slice i = req i
//            m_*    single command/data channel to the i2c_master
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_cmd_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 7
);
   // Requester side
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_cmd_address;
   logic [NUM_REQ-1:0]            req_cmd_start;
   logic [NUM_REQ-1:0]            req_cmd_read;
   logic [NUM_REQ-1:0]            req_cmd_write;
   logic [NUM_REQ-1:0]            req_cmd_write_multiple;
   logic [NUM_REQ-1:0]            req_cmd_stop;
   logic [NUM_REQ-1:0]            req_cmd_valid;
   logic [NUM_REQ-1:0]            req_cmd_ready;
   logic [NUM_REQ*8-1:0]          req_data_in;
   logic [NUM_REQ-1:0]            req_data_in_valid;
   logic [NUM_REQ-1:0]            req_data_in_last;
   logic [NUM_REQ-1:0]            req_data_in_ready;
   logic [7:0]                    req_data_out;
   logic [NUM_REQ-1:0]            req_data_out_valid;
   logic [NUM_REQ-1:0]            req_missed_ack;
   logic [NUM_REQ-1:0]            req_grant;

   // i2c_master side
   logic [ADDR_WIDTH-1:0]         m_cmd_address;
   logic                          m_cmd_start;
   logic                          m_cmd_read;
   logic                          m_cmd_write;
   logic                          m_cmd_write_multiple;
   logic                          m_cmd_stop;
   logic                          m_cmd_valid;
   logic                          m_cmd_ready;
   logic [7:0]                    m_data_in;
   logic                          m_data_in_valid;
   logic                          m_data_in_last;
   logic                          m_data_in_ready;
   logic [7:0]                    m_data_out;
   logic                          m_data_out_valid;
   logic                          m_missed_ack;
   logic                          m_busy;

   modport slave (
      input  req_cmd_address, req_cmd_start, req_cmd_read, req_cmd_write,
             req_cmd_write_multiple, req_cmd_stop, req_cmd_valid,
             req_data_in, req_data_in_valid, req_data_in_last,
             m_cmd_ready, m_data_in_ready, m_data_out, m_data_out_valid,
             m_missed_ack, m_busy,
      output req_cmd_ready, req_data_in_ready, req_data_out,
             req_data_out_valid, req_missed_ack, req_grant,
             m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write,
             m_cmd_write_multiple, m_cmd_stop, m_cmd_valid,
             m_data_in, m_data_in_valid, m_data_in_last
   );

   modport master (
      output req_cmd_address, req_cmd_start, req_cmd_read, req_cmd_write,
             req_cmd_write_multiple, req_cmd_stop, req_cmd_valid,
             req_data_in, req_data_in_valid, req_data_in_last,
             m_cmd_ready, m_data_in_ready, m_data_out, m_data_out_valid,
             m_missed_ack, m_busy,
      input  req_cmd_ready, req_data_in_ready, req_data_out,
             req_data_out_valid, req_missed_ack, req_grant,
             m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write,
             m_cmd_write_multiple, m_cmd_stop, m_cmd_valid,
             m_data_in, m_data_in_valid, m_data_in_last
   );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_cmd_arbiter
// Purpose  : Round-robin arbiter sharing one i2c_master between NUM_REQ
//            requesters. Ownership spans a whole I2C transaction (first
//            command through the command carrying stop), so transfers from
//            different requesters never interleave on the bus.
// Ports    : clk   - clock
//            reset - synchronous, active-high reset
//            bus   - i2c_cmd_arbiter_if.slave (requester and master channels);
//                    the interface parameters must match this module's
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cmd_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 7
) (
   input  wire logic         clk,
   input  wire logic         reset,
   i2c_cmd_arbiter_if.slave  bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   next_ptr;
   logic [IDX_W:0]     cand;
   logic               found;
   logic [NUM_REQ-1:0] grant;

   // Round-robin scan starting at rr_ptr; the extra cand bit holds the
   // unwrapped sum so the modulo works for non-power-of-two NUM_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NUM_REQ))
            cand = cand - (IDX_W+1)'(NUM_REQ);
         if (!found && bus.req_cmd_valid[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
   end

   assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt                = state;
      bus.m_cmd_address        = '0;
      bus.m_cmd_start          = 1'b0;
      bus.m_cmd_read           = 1'b0;
      bus.m_cmd_write          = 1'b0;
      bus.m_cmd_write_multiple = 1'b0;
      bus.m_cmd_stop           = 1'b0;
      bus.m_cmd_valid          = 1'b0;
      bus.m_data_in            = '0;
      bus.m_data_in_valid      = 1'b0;
      bus.m_data_in_last       = 1'b0;
      bus.req_cmd_ready        = '0;
      bus.req_data_in_ready    = '0;
      bus.req_data_out_valid   = '0;
      bus.req_missed_ack       = '0;
      bus.req_data_out         = bus.m_data_out;

      case (state)
         IDLE: begin
            if (found) state_nxt = GRANTED;
         end
         GRANTED: begin
            bus.m_cmd_address        = bus.req_cmd_address[owner*ADDR_WIDTH +: ADDR_WIDTH];
            bus.m_cmd_start          = bus.req_cmd_start[owner];
            bus.m_cmd_read           = bus.req_cmd_read[owner];
            bus.m_cmd_write          = bus.req_cmd_write[owner];
            bus.m_cmd_write_multiple = bus.req_cmd_write_multiple[owner];
            bus.m_cmd_stop           = bus.req_cmd_stop[owner];
            bus.m_cmd_valid          = bus.req_cmd_valid[owner];
            bus.req_cmd_ready[owner] = bus.m_cmd_ready;
            if (bus.req_cmd_valid[owner] && bus.m_cmd_ready && bus.req_cmd_stop[owner])
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!bus.m_busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Write data keeps flowing in DRAIN: a write_multiple command carrying
      // stop still pulls its bytes after the command itself is accepted.
      if (state == GRANTED || state == DRAIN) begin
         bus.m_data_in                = bus.req_data_in[owner*8 +: 8];
         bus.m_data_in_valid          = bus.req_data_in_valid[owner];
         bus.m_data_in_last           = bus.req_data_in_last[owner];
         bus.req_data_in_ready[owner] = bus.m_data_in_ready;
         bus.req_data_out_valid[owner] = bus.m_data_out_valid;
         bus.req_missed_ack[owner]     = bus.m_missed_ack;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner  <= '0;
         rr_ptr <= '0;
         grant  <= '0;
      end else if (state == IDLE && found) begin
         owner <= pick;
         grant <= NUM_REQ'(1) << pick;
      end else if (state == DRAIN && !bus.m_busy) begin
         rr_ptr <= next_ptr;
         grant  <= '0;
      end
   end

   assign bus.req_grant = grant;
endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_cmd_arbiter
// Purpose  : Directed self-checking bench for i2c_cmd_arbiter with two
//            requesters and 7-bit addresses.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_arbiter;
   localparam int NUM_REQ    = 2;
   localparam int ADDR_WIDTH = 7;

   logic clk;
   logic reset;
   int   total;
   int   passed;
   int   failed;

   i2c_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   i2c_cmd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cmd(input int r, input logic [6:0] a, input logic s, input logic rd,
                            input logic wr, input logic st, input logic v);
      bus.req_cmd_address[r*ADDR_WIDTH +: ADDR_WIDTH] = a;
      bus.req_cmd_start[r]          = s;
      bus.req_cmd_read[r]           = rd;
      bus.req_cmd_write[r]          = wr;
      bus.req_cmd_write_multiple[r] = 1'b0;
      bus.req_cmd_stop[r]           = st;
      bus.req_cmd_valid[r]          = v;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      failed = 0;
      reset  = 1'b1;
      bus.req_cmd_address        = '0;
      bus.req_cmd_start          = '0;
      bus.req_cmd_read           = '0;
      bus.req_cmd_write          = '0;
      bus.req_cmd_write_multiple = '0;
      bus.req_cmd_stop           = '0;
      bus.req_cmd_valid          = '0;
      bus.req_data_in            = '0;
      bus.req_data_in_valid      = '0;
      bus.req_data_in_last       = '0;
      bus.m_cmd_ready            = 1'b1;
      bus.m_data_in_ready        = 1'b0;
      bus.m_data_out             = '0;
      bus.m_data_out_valid       = 1'b0;
      bus.m_missed_ack           = 1'b0;
      bus.m_busy                 = 1'b0;
      tick(); tick(); tick();
      reset = 1'b0;
      #1;

      // Reset state
      chk("rst_grant",     bus.req_grant, 2'b00);
      chk("rst_cmd_ready", bus.req_cmd_ready, 2'b00);
      chk("rst_din_ready", bus.req_data_in_ready, 2'b00);
      chk("rst_dout_vld",  bus.req_data_out_valid, 2'b00);
      chk("rst_mack",      bus.req_missed_ack, 2'b00);
      chk("rst_m_valid",   bus.m_cmd_valid, 1'b0);
      chk("rst_m_din_vld", bus.m_data_in_valid, 1'b0);
      chk("rst_rr_ptr",    dut.rr_ptr, 0);

      // Single requester 0: start+write 0x55, then stop+write
      tick();
      drive_cmd(0, 7'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("t1_idle_no_fwd", bus.m_cmd_valid, 1'b0);
      chk("t1_idle_grant",  bus.req_grant, 2'b00);
      tick();
      bus.m_busy = 1'b1;
      #1;
      chk("t1_grant",  bus.req_grant, 2'b01);
      chk("t1_mvalid", bus.m_cmd_valid, 1'b1);
      chk("t1_addr",   bus.m_cmd_address, 7'h55);
      chk("t1_start",  bus.m_cmd_start, 1'b1);
      chk("t1_write",  bus.m_cmd_write, 1'b1);
      chk("t1_stop0",  bus.m_cmd_stop, 1'b0);
      chk("t1_ready",  bus.req_cmd_ready, 2'b01);
      tick();
      drive_cmd(0, 7'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      chk("t1_stop1",   bus.m_cmd_stop, 1'b1);
      chk("t1_start0",  bus.m_cmd_start, 1'b0);
      chk("t1_addr2",   bus.m_cmd_address, 7'h55);
      tick();
      drive_cmd(0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("t1_drain_mvalid", bus.m_cmd_valid, 1'b0);
      chk("t1_drain_ready",  bus.req_cmd_ready, 2'b00);
      chk("t1_drain_grant",  bus.req_grant, 2'b01);
      tick();
      #1;
      chk("t1_drain_busy_grant", bus.req_grant, 2'b01);
      bus.m_busy = 1'b0;
      tick();
      #1;
      chk("t1_release_grant", bus.req_grant, 2'b00);
      chk("t1_rr_ptr",        dut.rr_ptr, 1);

      // Simultaneous requests from reset; m_busy stays low so DRAIN is one cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_cmd(0, 7'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive_cmd(1, 7'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("t2_rr_ptr_rst", dut.rr_ptr, 0);
      tick();
      #1;
      chk("t2_grant0", bus.req_grant, 2'b01);
      chk("t2_addr0",  bus.m_cmd_address, 7'h11);
      chk("t2_ready0", bus.req_cmd_ready, 2'b01);
      tick();
      drive_cmd(0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("t2_drain_grant", bus.req_grant, 2'b01);
      chk("t2_drain_ready", bus.req_cmd_ready, 2'b00);
      tick();
      #1;
      chk("t2_idle_grant", bus.req_grant, 2'b00);
      chk("t2_rr_ptr1",    dut.rr_ptr, 1);
      tick();
      bus.m_missed_ack     = 1'b1;
      bus.m_data_out       = 8'hA7;
      bus.m_data_out_valid = 1'b1;
      #1;
      chk("t2_grant1",  bus.req_grant, 2'b10);
      chk("t2_addr1",   bus.m_cmd_address, 7'h22);
      chk("t2_read1",   bus.m_cmd_read, 1'b1);
      chk("t2_ready1",  bus.req_cmd_ready, 2'b10);
      chk("t2_mack",    bus.req_missed_ack, 2'b10);
      chk("t2_dout",    bus.req_data_out, 8'hA7);
      chk("t2_dout_vld", bus.req_data_out_valid, 2'b10);
      tick();
      drive_cmd(1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.m_missed_ack     = 1'b0;
      bus.m_data_out_valid = 1'b0;
      #1;
      chk("t2_mack_pulse", bus.req_missed_ack, 2'b00);
      chk("t2_dout_vld0",  bus.req_data_out_valid, 2'b00);
      chk("t2_drain1_grant", bus.req_grant, 2'b10);
      tick();
      bus.m_data_out_valid = 1'b1;
      bus.m_missed_ack     = 1'b1;
      #1;
      chk("t2_rr_ptr0",       dut.rr_ptr, 0);
      chk("t2_idle_grant2",   bus.req_grant, 2'b00);
      chk("t2_idle_dout_vld", bus.req_data_out_valid, 2'b00);
      chk("t2_idle_mack",     bus.req_missed_ack, 2'b00);
      bus.m_data_out_valid = 1'b0;
      bus.m_missed_ack     = 1'b0;

      // Req1 waits while req0 runs a 3-command transaction with write data
      drive_cmd(0, 7'h30, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      drive_cmd(1, 7'h4F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      bus.req_data_in       = {8'hEE, 8'h3C};
      bus.req_data_in_valid = 2'b11;
      bus.req_data_in_last  = 2'b11;
      bus.m_data_in_ready   = 1'b1;
      tick();
      bus.m_busy = 1'b1;
      #1;
      chk("t3_grant0",   bus.req_grant, 2'b01);
      chk("t3_c1_addr",  bus.m_cmd_address, 7'h30);
      chk("t3_c1_ready", bus.req_cmd_ready, 2'b01);
      chk("t3_din",      bus.m_data_in, 8'h3C);
      chk("t3_din_vld",  bus.m_data_in_valid, 1'b1);
      chk("t3_din_last", bus.m_data_in_last, 1'b1);
      chk("t3_din_rdy",  bus.req_data_in_ready, 2'b01);
      tick();
      drive_cmd(0, 7'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("t3_c2_addr",  bus.m_cmd_address, 7'h30);
      chk("t3_c2_ready", bus.req_cmd_ready, 2'b01);
      chk("t3_c2_stop",  bus.m_cmd_stop, 1'b0);
      tick();
      drive_cmd(0, 7'h30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      chk("t3_c3_addr",  bus.m_cmd_address, 7'h30);
      chk("t3_c3_ready", bus.req_cmd_ready, 2'b01);
      chk("t3_c3_stop",  bus.m_cmd_stop, 1'b1);
      tick();
      drive_cmd(0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.req_data_in_valid = 2'b00;
      #1;
      chk("t3_drain_ready",  bus.req_cmd_ready, 2'b00);
      chk("t3_drain_mvalid", bus.m_cmd_valid, 1'b0);
      chk("t3_drain_grant",  bus.req_grant, 2'b01);
      bus.m_busy = 1'b0;
      tick();
      #1;
      chk("t3_idle_grant", bus.req_grant, 2'b00);
      chk("t3_rr_ptr1",    dut.rr_ptr, 1);
      tick();
      #1;
      chk("t3_grant1", bus.req_grant, 2'b10);
      chk("t3_addr1",  bus.m_cmd_address, 7'h4F);
      chk("t3_mvalid", bus.m_cmd_valid, 1'b1);

      // Reset while GRANTED with a command pending
      reset = 1'b1;
      tick();
      #1;
      chk("t4_rst_grant",  bus.req_grant, 2'b00);
      chk("t4_rst_mvalid", bus.m_cmd_valid, 1'b0);
      chk("t4_rst_rr_ptr", dut.rr_ptr, 0);
      chk("t4_rst_ready",  bus.req_cmd_ready, 2'b00);
      reset = 1'b0;
      drive_cmd(1, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one i2c_master command/data interface between NumReq independent requesters, e.g. the Si570 clock controller and an SFP/temperature poller on the same board I2C bus.
- Grants whole I2C transactions, from the first command through the command carrying stop, so transfers from different requesters never interleave on the bus.
- Arbitration is round-robin among pending requesters.
- Routes write data to the master, and routes read data and missed_ack back to the current owner only.

Parameters:
NumReq, 2, number of requesters (2..8)
AddrWidth, 7, I2C address width per requester

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_cmd_address  in  NumReq*AddrWidth  per-requester target address, slice i = requester i
req_cmd_start/read/write/write_multiple/stop  in  NumReq each  per-requester command flags
req_cmd_valid  in  NumReq  command valid
req_cmd_ready  out  NumReq  command accepted
req_data_in  in  NumReq*8  write data
req_data_in_valid/last  in  NumReq each  write data valid/last
req_data_in_ready  out  NumReq  write data ready
req_data_out  out  8  read data, broadcast to all requesters
req_data_out_valid  out  NumReq  read data valid, owner only
req_missed_ack  out  NumReq  missed-ACK pulse, owner only
req_grant  out  NumReq  one-hot current owner
m_cmd_address  out  AddrWidth  to i2c_master
m_cmd_start/read/write/write_multiple/stop  out  1 each  to i2c_master
m_cmd_valid  out  1  to i2c_master
m_cmd_ready  in  1  from i2c_master
m_data_in  out  8  to i2c_master
m_data_in_valid/last  out  1 each  to i2c_master
m_data_in_ready  in  1  from i2c_master
m_data_out  in  8  from i2c_master
m_data_out_valid  in  1  from i2c_master
m_missed_ack  in  1  from i2c_master
m_busy  in  1  from i2c_master

Behaviour:
- Reset state:
  - FSM in IDLE, rr_ptr=0.
  - req_grant, req_cmd_ready, req_data_in_ready, req_data_out_valid, req_missed_ack all 0.
  - m_cmd_valid=0, m_data_in_valid=0.
- FSM IDLE:
  - If any req_cmd_valid bit is set, choose the first index i scanning rr_ptr, rr_ptr+1, … modulo NumReq.
  - Register owner=i; enter GRANTED next cycle.
  - Grant latency is 1 cycle from valid.
  - No command is forwarded while in IDLE.
- FSM GRANTED:
  - Owner's command fields and valid pass combinationally to m_cmd_*.
  - req_cmd_ready[owner] = m_cmd_ready; all other ready bits = 0.
  - Data-in channel is muxed the same way.
  - A cycle with m_cmd_valid & m_cmd_ready & m_cmd_stop moves the FSM to DRAIN.
- FSM DRAIN:
  - m_cmd_valid=0 and all req_cmd_ready=0.
  - When m_busy=0: rr_ptr <= owner+1 (wraps to 0 at NumReq), req_grant <= 0, go to IDLE.
  - DRAIN lasts at least 1 cycle even if m_busy is already 0.
- Non-owner requesters: valid may stay asserted indefinitely and must not be dropped. The arbiter never asserts ready to a non-owner.
- Owner withdraws valid mid-transaction without stop: the grant is held indefinitely. The bus stays owned; no timeout in this revision.
- Read data:
  - req_data_out = m_data_out for all requesters.
  - req_data_out_valid[owner] = m_data_out_valid, in GRANTED and DRAIN.
  - Output is 0 for everyone in IDLE; data arriving in IDLE is discarded.
- req_missed_ack[owner] = m_missed_ack, combinational, in GRANTED/DRAIN only.
- Simultaneous requests: the rr_ptr scan order decides. A requester re-requesting in the IDLE cycle right after its release loses to any other pending requester.
- req_grant is one-hot or zero, registered, and equals owner during GRANTED and DRAIN.
- Reset mid-transaction: immediate return to reset state the next cycle. The i2c_master is on the same reset; no stop is issued.

Test Plan:
- Single requester 0 issues write addr 0x55 (start+write), then stop+write → grant[0] 1 cycle after valid, both cmds reach m_cmd_* unchanged, DRAIN until m_busy=0, grant=0, rr_ptr=1.
- Req0 and req1 valid in the same cycle from reset → req0 granted; after its stop and drain, req1 granted with no idle gap beyond 1 IDLE cycle; rr_ptr ends at 0.
- Req1 holds valid while req0 runs a 3-command transaction → req_cmd_ready[1]=0 throughout and no req1 field appears on m_cmd_*.
- Owner performs a read of byte 0xA7 → req_data_out_valid pulses only on owner bit, req_data_out=0xA7; a spurious m_data_out_valid in IDLE → no valid bit asserted.
- m_missed_ack pulse during req1 ownership → req_missed_ack=2'b10 for that cycle only.
- Reset asserted in GRANTED with m_cmd_valid high → next cycle grant=0, m_cmd_valid=0, rr_ptr=0.
